// File: rtl/bk_add_pkg.sv
// Shared definitions for the multi-precision Brent-Kung adder stage.
package bk_add_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/bk_add16_ci.sv
// 16-bit Brent-Kung prefix adder with carry-in, purely combinational.
// The carry-in is folded into the bit-0 generate term, so every group
// generate G[i:0] already accounts for it.
module bk_add16_ci
    import bk_add_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  logic  cin,
    output word_t sum,
    output logic  cout
);

    word_t p_bit;
    word_t g_bit;
    word_t g_pre;
    word_t p_pre;
    word_t carry_in;

    // Bit-level propagate/generate, with the carry-in absorbed into bit 0
    always_comb begin
        p_bit    = a ^ b;
        g_bit    = a & b;
        g_bit[0] = (a[0] & b[0]) | (p_bit[0] & cin);
    end

    // Brent-Kung up-sweep then down-sweep to form all prefix generates
    always_comb begin
        g_pre = g_bit;
        p_pre = p_bit;
        for (int l = 0; l < 4; l++) begin
            for (int i = (2 << l) - 1; i < WORD_W; i += (2 << l)) begin
                g_pre[i] = g_pre[i] | (p_pre[i] & g_pre[i - (1 << l)]);
                p_pre[i] = p_pre[i] & p_pre[i - (1 << l)];
            end
        end
        for (int l = 2; l >= 0; l--) begin
            for (int i = (2 << l) - 1 + (1 << l); i < WORD_W; i += (2 << l)) begin
                g_pre[i] = g_pre[i] | (p_pre[i] & g_pre[i - (1 << l)]);
                p_pre[i] = p_pre[i] & p_pre[i - (1 << l)];
            end
        end
    end

    // Carry into each bit is the prefix generate of all bits below it
    always_comb begin
        carry_in = {g_pre[WORD_W-2:0], cin};
        sum      = p_bit ^ carry_in;
        cout     = g_pre[WORD_W-1];
    end

endmodule

// File: rtl/bk_mp_add_seq.sv
// Sequential multi-precision adder: streams 16-bit operand words LSW first,
// chains the inter-word carry in a register and emits registered sum words.
// Optional macro BKADD_SUB_EN adds an in_sub port that turns the transaction
// into A-B (out_cout then means "no borrow").
module bk_mp_add_seq
    import bk_add_pkg::*;
#(
    parameter int MAX_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_last,
`ifdef BKADD_SUB_EN
    input  logic        in_sub,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_last,
    output logic        out_cout,
    output logic        len_err,
    output logic        busy
);

    localparam int CNT_W = $clog2(MAX_WORDS) + 1;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             carry;
    logic             accept;
    logic             first_word;
    logic             at_max;
    logic             word_last;
    logic             sub_now;
    logic             cin;
    word_t            b_eff;
    word_t            sum;
    logic             c_next;

    assign in_ready   = !out_valid || out_ready;
    assign accept     = in_valid && in_ready;
    assign first_word = (count == '0);
    assign at_max     = (count == CNT_W'(MAX_WORDS - 1));
    assign word_last  = in_last || at_max;
    assign busy       = (count != '0);

`ifdef BKADD_SUB_EN
    logic sub_reg;

    assign sub_now = first_word ? in_sub : sub_reg;

    // Latch the subtract mode on the first word and keep it for the transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_reg <= 1'b0;
        end else if (accept && first_word) begin
            sub_reg <= in_sub;
        end
    end
`else
    assign sub_now = 1'b0;
`endif

    assign b_eff = sub_now ? ~in_b : in_b;
    assign cin   = first_word ? sub_now : carry;

    bk_add16_ci u_add (
        .a    (in_a),
        .b    (b_eff),
        .cin  (cin),
        .sum  (sum),
        .cout (c_next)
    );

    // Transaction FSM, carry chain and registered output word
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            count     <= '0;
            carry     <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_last  <= 1'b0;
            out_cout  <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            len_err <= 1'b0;
            if (accept) begin
                out_valid <= 1'b1;
                out_sum   <= sum;
                out_last  <= word_last;
                out_cout  <= word_last ? c_next : 1'b0;
                len_err   <= at_max && !in_last;
                if (word_last) begin
                    state <= ST_IDLE;
                    count <= '0;
                    carry <= 1'b0;
                end else begin
                    state <= ST_ACTIVE;
                    count <= count + CNT_W'(1);
                    carry <= c_next;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bk_mp_add_seq.sv
// Self-checking bench for bk_mp_add_seq (built with MAX_WORDS=4).
module tb_bk_mp_add_seq;

    localparam int MAXW = 4;

    typedef struct packed {
        logic [15:0] sum;
        logic        last;
        logic        cout;
        logic        lerr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_last;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_last;
    logic        out_cout;
    logic        len_err;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;
    int lerr_seen  = 0;

    exp_t sb[$];

    int   m_cnt   = 0;
    logic m_carry = 1'b0;
    logic m_sub   = 1'b0;

    bk_mp_add_seq #(.MAX_WORDS(MAXW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
`ifdef BKADD_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .len_err   (len_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Count len_err pulses seen between edges
    always @(negedge clk) begin
        if (len_err) lerr_seen++;
    end

    // Scoreboard: compare every handshaken output word with the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            compared++;
            assert (sb.size() != 0) else begin
                mismatched++;
                $error("[TB] FAIL sb_empty: got sum=%h with no expected word", out_sum);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                compared++;
                assert (out_sum === e.sum) else begin
                    mismatched++;
                    $error("[TB] FAIL sum: got %h expected %h", out_sum, e.sum);
                end
                compared++;
                assert (out_last === e.last) else begin
                    mismatched++;
                    $error("[TB] FAIL last: got %b expected %b (sum %h)", out_last, e.last, e.sum);
                end
                compared++;
                assert (out_cout === e.cout) else begin
                    mismatched++;
                    $error("[TB] FAIL cout: got %b expected %b (sum %h)", out_cout, e.cout, e.sum);
                end
                compared++;
                assert (len_err === e.lerr) else begin
                    mismatched++;
                    $error("[TB] FAIL len_err: got %b expected %b (sum %h)", len_err, e.lerr, e.sum);
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Drive one word, wait (bounded) for acceptance, push the model's expectation.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic last, input logic s, output int waited);
        logic [16:0] full;
        logic        first, atmax, sub_now, cin, lastf;
        bit          ok;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_sub   = s;
        waited   = 0;
        ok       = 1'b0;
        while (!ok && waited < 50) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else waited++;
        end
        compared++;
        assert (ok) else begin
            mismatched++;
            $error("[TB] FAIL accept_timeout: word a=%h not accepted after %0d cycles, required 50 max", a, waited);
        end
        first   = (m_cnt == 0);
        atmax   = (m_cnt == MAXW - 1);
`ifdef BKADD_SUB_EN
        sub_now = first ? s : m_sub;
`else
        sub_now = 1'b0;
`endif
        cin     = first ? sub_now : m_carry;
        full    = {1'b0, a} + {1'b0, (sub_now ? ~b : b)} + {16'd0, cin};
        lastf   = last || atmax;
        if (ok) sb.push_back('{full[15:0], lastf, lastf & full[16], atmax & !last});
        if (lastf) begin
            m_cnt   = 0;
            m_carry = 1'b0;
        end else begin
            m_cnt++;
            m_carry = full[16];
        end
        m_sub = sub_now;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        compared++;
        assert (sb.size() == 0) else begin
            mismatched++;
            $error("[TB] FAIL drain: %0d words outstanding, required 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        int l0;
        logic [15:0] held;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        in_sub    = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_sum",   32'(out_sum),   32'd0);
        checkOutput("rst_out_last",  32'(out_last),  32'd0);
        checkOutput("rst_out_cout",  32'(out_cout),  32'd0);
        checkOutput("rst_len_err",   32'(len_err),   32'd0);
        checkOutput("rst_busy",      32'(busy),      32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);

        // Single word
        applyStimulus(16'h00FF, 16'h0001, 1'b1, 1'b0, w);
        checkOutput("single_sum", 32'(out_sum), 32'h0100);
        checkOutput("single_cout", 32'(out_cout), 32'd0);
        drain();

        // Two-word carry chain
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, w);
        checkOutput("chain_busy", 32'(busy), 32'd1);
        checkOutput("chain_mid_cout", 32'(out_cout), 32'd0);
        applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0, w);
        checkOutput("chain_sum_hi", 32'(out_sum), 32'h0001);
        drain();

        // Full overflow, then carry must not leak into next transaction
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, w);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, w);
        checkOutput("ovf_cout", 32'(out_cout), 32'd1);
        applyStimulus(16'h0001, 16'h0001, 1'b1, 1'b0, w);
        checkOutput("ovf_next_sum", 32'(out_sum), 32'h0002);
        drain();

        // Backpressure: stall output for 3 cycles with a word waiting
        out_ready = 1'b0;
        applyStimulus(16'h1234, 16'h1111, 1'b1, 1'b0, w);
        held     = out_sum;
        checkOutput("bp_held_val", 32'(held), 32'h2345);
        in_valid = 1'b1;
        in_a     = 16'h0F0F;
        in_b     = 16'h0101;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
            checkOutput("bp_sum_stable", 32'(out_sum), 32'(held));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        applyStimulus(16'h0F0F, 16'h0101, 1'b1, 1'b0, w);
        checkOutput("bp_release_wait", 32'(w), 32'd0);
        applyStimulus(16'hA000, 16'h0A00, 1'b1, 1'b0, w);
        checkOutput("bp_b2b_wait", 32'(w), 32'd0);
        drain();

        // Length error: 5 words without last
        l0 = lerr_seen;
        applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b0, w);
        applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0, w);
        applyStimulus(16'hFFFF, 16'h0000, 1'b0, 1'b0, w);
        applyStimulus(16'h7FFF, 16'h8000, 1'b0, 1'b0, w);
        checkOutput("lerr_last", 32'(out_last), 32'd1);
        checkOutput("lerr_busy_clr", 32'(busy), 32'd0);
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, w);
        checkOutput("lerr_new_sum", 32'(out_sum), 32'hFFFE);
        applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0, w);
        drain();
        checkOutput("lerr_pulses", 32'(lerr_seen - l0), 32'd1);

        // Reset mid-transaction with the first word still pending
        out_ready = 1'b0;
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_cnt   = 0;
        m_carry = 1'b0;
        m_sub   = 1'b0;
        checkOutput("mrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("mrst_out_sum",   32'(out_sum),   32'd0);
        checkOutput("mrst_out_last",  32'(out_last),  32'd0);
        checkOutput("mrst_out_cout",  32'(out_cout),  32'd0);
        checkOutput("mrst_busy",      32'(busy),      32'd0);
        out_ready = 1'b1;
`ifdef BKADD_SUB_EN
        applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1, w);
        checkOutput("fresh_sub_sum", 32'(out_sum), 32'hFFFE);
        checkOutput("fresh_sub_cout", 32'(out_cout), 32'd0);
        applyStimulus(16'h0000, 16'h0001, 1'b0, 1'b1, w);
        applyStimulus(16'h0001, 16'h0000, 1'b1, 1'b0, w);
        checkOutput("sub2_sum_hi", 32'(out_sum), 32'h0000);
        checkOutput("sub2_cout", 32'(out_cout), 32'd1);
`else
        applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b0, w);
        checkOutput("fresh_sum", 32'(out_sum), 32'h000C);
        checkOutput("fresh_cout", 32'(out_cout), 32'd0);
`endif
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
